// File: rtl/clock_time_counter.sv
`default_nettype none
// ============================================================================
// Module  : clock_time_counter
// Brief   : 24-hour timekeeping core with a 1 Hz prescaler and a button-driven
//           set mode for hours and minutes.
// Rev     : 1.0
// ============================================================================
module clock_time_counter #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [5:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       sec_tick,
    output logic       set_active
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] C_PRESCALE_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic [5:0]    hours_q, hours_d;
    logic [5:0]    minutes_q, minutes_d;
    logic [5:0]    seconds_q, seconds_d;
    logic          sec_tick_q, sec_tick_d;
    logic          inc_min_prev_q, inc_hr_prev_q;
    logic          w_min_edge, w_hr_edge;

    assign w_min_edge = inc_min & ~inc_min_prev_q;
    assign w_hr_edge  = inc_hr & ~inc_hr_prev_q;

    // The state change acts on the sampling edge, so the datapath keys off
    // state_d; this is what lets SET win over a coincident prescaler wrap.
    always_comb begin
        state_d    = set_mode ? ST_SET : ST_RUN;
        prescale_d = prescale_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        sec_tick_d = 1'b0;

        if (state_d == ST_SET) begin
            prescale_d = '0;
            seconds_d  = '0;
            if (w_min_edge) begin
                minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
            end
            if (w_hr_edge) begin
                hours_d = (hours_q == 6'd23) ? 6'd0 : hours_q + 6'd1;
            end
        end else if (prescale_q == C_PRESCALE_LAST) begin
            prescale_d = '0;
            sec_tick_d = 1'b1;
            if (seconds_q == 6'd59) begin
                seconds_d = 6'd0;
                if (minutes_q == 6'd59) begin
                    minutes_d = 6'd0;
                    hours_d   = (hours_q == 6'd23) ? 6'd0 : hours_q + 6'd1;
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end else begin
            prescale_d = prescale_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            prescale_q     <= '0;
            hours_q        <= '0;
            minutes_q      <= '0;
            seconds_q      <= '0;
            sec_tick_q     <= 1'b0;
            inc_min_prev_q <= 1'b0;
            inc_hr_prev_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            prescale_q     <= prescale_d;
            hours_q        <= hours_d;
            minutes_q      <= minutes_d;
            seconds_q      <= seconds_d;
            sec_tick_q     <= sec_tick_d;
            inc_min_prev_q <= inc_min;
            inc_hr_prev_q  <= inc_hr;
        end
    end

    assign hours      = hours_q;
    assign minutes    = minutes_q;
    assign seconds    = seconds_q;
    assign sec_tick   = sec_tick_q;
    assign set_active = (state_q == ST_SET);

endmodule
`default_nettype wire

// File: tb/tb_clock_time_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_time_counter
// Brief   : Directed self-checking bench for clock_time_counter (4 ticks/s).
// Rev     : 1.0
// ============================================================================
module tb_clock_time_counter;

    localparam int C_TPS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       set_mode = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_hr = 1'b0;
    logic [5:0] hours, minutes, seconds;
    logic       sec_tick, set_active;

    int n_checks = 0;
    int n_fail   = 0;

    clock_time_counter #(.TICKS_PER_SEC(C_TPS)) dut (
        .clk        (clk),
        .reset      (reset),
        .set_mode   (set_mode),
        .inc_min    (inc_min),
        .inc_hr     (inc_hr),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .sec_tick   (sec_tick),
        .set_active (set_active)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; inputs change and outputs are sampled 1 ns later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hours"}, 32'(hours), 32'(h));
        check({tag, ".minutes"}, 32'(minutes), 32'(m));
        check({tag, ".seconds"}, 32'(seconds), 32'(s));
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            inc_min = 1'b1; step(1);
            inc_min = 1'b0; step(1);
        end
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            inc_hr = 1'b1; step(1);
            inc_hr = 1'b0; step(1);
        end
    endtask

    initial begin
        // Power-on reset
        reset = 1'b1;
        step(3);
        check_time("reset", 0, 0, 0);
        check("reset.sec_tick", 32'(sec_tick), 0);
        check("reset.set_active", 32'(set_active), 0);
        reset = 1'b0;

        // First tick on the 4th edge after release, then every 4 cycles
        step(3);
        check("pre_tick.sec_tick", 32'(sec_tick), 0);
        check("pre_tick.seconds", 32'(seconds), 0);
        step(1);
        check("tick1.sec_tick", 32'(sec_tick), 1);
        check("tick1.seconds", 32'(seconds), 1);
        step(1);
        check("tick1_end.sec_tick", 32'(sec_tick), 0);
        step(2);
        check("pre_tick2.sec_tick", 32'(sec_tick), 0);
        step(1);
        check("tick2.sec_tick", 32'(sec_tick), 1);
        check("tick2.seconds", 32'(seconds), 2);

        // Enter SET on the edge where the prescaler would wrap
        step(3);
        check("pre_set.seconds", 32'(seconds), 2);
        set_mode = 1'b1;
        step(1);
        check("set_wrap.sec_tick", 32'(sec_tick), 0);
        check("set_wrap.seconds", 32'(seconds), 0);
        check("set_wrap.set_active", 32'(set_active), 1);

        // Minute stepping 58 -> 59 -> 0 -> 1, no carry into hours
        pulse_min(58);
        check("min58", 32'(minutes), 58);
        pulse_min(1);
        check("min59", 32'(minutes), 59);
        pulse_min(1);
        check_time("min_wrap", 0, 0, 0);
        pulse_min(1);
        check_time("min1", 0, 1, 0);

        // Hour stepping 23 -> 0
        pulse_hr(23);
        check("hr23", 32'(hours), 23);
        pulse_hr(1);
        check_time("hr_wrap", 0, 1, 0);

        // Held button gives exactly one increment
        inc_hr = 1'b1;
        step(10);
        inc_hr = 1'b0;
        step(1);
        check("held_hr", 32'(hours), 1);

        // Simultaneous edges apply both increments
        inc_min = 1'b1; inc_hr = 1'b1;
        step(1);
        check("both.hours", 32'(hours), 2);
        check("both.minutes", 32'(minutes), 2);
        inc_min = 1'b0; inc_hr = 1'b0;
        step(1);

        // Full rollover from 23:59:00
        pulse_hr(21);
        pulse_min(57);
        check_time("preset_2359", 23, 59, 0);
        set_mode = 1'b0;
        step(1);
        check("run.set_active", 32'(set_active), 0);
        step(238);
        check_time("before_roll", 23, 59, 59);
        step(1);
        check_time("after_roll", 0, 0, 0);
        check("roll.sec_tick", 32'(sec_tick), 1);

        // Button edges ignored in RUN
        inc_min = 1'b1; inc_hr = 1'b1;
        step(1);
        inc_min = 1'b0; inc_hr = 1'b0;
        step(1);
        check("run_buttons.hours", 32'(hours), 0);
        check("run_buttons.minutes", 32'(minutes), 0);

        // Reset mid-run at 00:01:30
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(360);
        check_time("at_0130", 0, 1, 30);
        reset = 1'b1;
        step(1);
        check_time("mid_reset", 0, 0, 0);
        check("mid_reset.sec_tick", 32'(sec_tick), 0);
        reset = 1'b0;
        step(3);
        check("re_pre_tick.sec_tick", 32'(sec_tick), 0);
        step(1);
        check("re_tick.sec_tick", 32'(sec_tick), 1);
        check("re_tick.seconds", 32'(seconds), 1);

        // Button already high when SET is entered produces no increment
        inc_min = 1'b1;
        step(1);
        set_mode = 1'b1;
        step(2);
        check("prehigh.minutes", 32'(minutes), 0);
        check("prehigh.set_active", 32'(set_active), 1);
        inc_min = 1'b0;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_time_counter.md
# clock_time_counter

Timekeeping core of the digital clock. Divides the system clock down to a 1 Hz tick and keeps 24-hour time in binary hours (0–23), minutes (0–59) and seconds (0–59). Provides a set mode in which the user steps minutes and hours with push-button pulses. The `hours` and `minutes` outputs drive the downstream two-digit seven-segment display stages directly, one display per value, each taking a 6-bit 0–59 input.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per second. Must be ≥ 2. The prescaler is `$clog2(TICKS_PER_SEC)` bits wide.
- `clk` in 1: system clock. The block uses one clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset. Takes priority over all other inputs.
- `set_mode` in 1: level input. 1 selects SET, 0 selects RUN. Already synchronous to `clk`.
- `inc_min` in 1: minute-step button, synchronous to `clk`. Acts on its rising edge only.
- `inc_hr` in 1: hour-step button, synchronous to `clk`. Acts on its rising edge only.
- `hours` out 6: binary 0–23.
- `minutes` out 6: binary 0–59.
- `seconds` out 6: binary 0–59.
- `sec_tick` out 1: one-cycle pulse in each cycle where `seconds` has just advanced.
- `set_active` out 1: registered copy of the state; 1 while in SET.

## Operation
- State machine has two states, RUN and SET.
  - RUN → SET when `set_mode`=1 is sampled.
  - SET → RUN when `set_mode`=0 is sampled.
  - The state change takes effect on the same edge that samples `set_mode`.
- RUN:
  - The prescaler counts 0 … TICKS_PER_SEC-1, then wraps to 0.
  - On the wrapping edge, `seconds` increments.
  - `seconds` 59→0 carries into `minutes`; `minutes` 59→0 carries into `hours`; `hours` 23→0.
  - 23:59:59 rolls over to 00:00:00.
  - Button edges are ignored.
- SET:
  - Prescaler and `seconds` are forced to 0.
  - A rising edge on `inc_min` increments `minutes` modulo 60, with no carry into `hours`.
  - A rising edge on `inc_hr` increments `hours` modulo 24.
  - Edges on both buttons in the same cycle apply both increments.
- Edge detection: a previous-value register per button is updated every cycle in both states and is cleared by reset.
  - A button already high when SET is entered produces no increment.
  - A held button produces exactly one increment.
- Leaving SET: the prescaler restarts at 0, so the first `sec_tick` comes TICKS_PER_SEC cycles after the first RUN cycle.
- Arithmetic: wrap limits are compared exactly (59, 23). Values outside the legal ranges are unreachable from reset.

## Timing
- Reset values: `hours`=0, `minutes`=0, `seconds`=0, `sec_tick`=0, `set_active`=0, prescaler=0, state=RUN, edge registers=0.
- Seconds advance: with reset released before edge 0, the TICKS_PER_SEC-th following rising edge sets `seconds`=1 and `sec_tick`=1 for exactly one cycle.
- Steady state: `sec_tick` period is exactly TICKS_PER_SEC cycles.
- Button response: if `inc_min`/`inc_hr` rises at sampling edge N (previous value 0), the new value is visible after edge N.
- Simultaneous events:
  - `set_mode` rising on the edge where the prescaler would wrap: SET wins. No second increment and no `sec_tick`; `seconds` is cleared.
  - `reset` concurrent with anything: reset wins.
- Reset mid-operation: all state returns to reset values on that edge, regardless of state.
- Outputs are all registered; there is no combinational path from input to output.

## Test plan
- Reset behaviour (TICKS_PER_SEC=4): hold `reset` 3 cycles, then release.
  - Required: all outputs 0.
  - `sec_tick` first pulses on the 4th edge after release, with `seconds`=1.
  - `sec_tick` then pulses every 4 cycles.
- Full rollover: in SET, step `hours` to 23 and `minutes` to 59, then drop `set_mode`.
  - Required: after 240 cycles, time is 00:00:00.
  - On the edge before that, time reads 23:59:59.
- Set-mode stepping: in SET with `minutes`=58, give 3 separate `inc_min` pulses.
  - Required: `minutes` = 59, 0, 1.
  - `hours` is unchanged and `seconds` stays 0.
  - `inc_hr` from 23 gives 0.
- Held and simultaneous buttons:
  - `inc_hr` held high for 10 cycles in SET: exactly +1.
  - `inc_min` and `inc_hr` rising in the same cycle: both +1.
  - Button edges in RUN: no change.
- Reset mid-run: at 00:01:30, assert `reset` for 1 cycle.
  - Required: all zero on the next cycle.
  - Counting restarts with the same cadence as after power-on reset.
- Set entry at a tick boundary: assert `set_mode` on the edge where the prescaler equals 3 (TICKS_PER_SEC=4).
  - Required: no `sec_tick`, `seconds`=0, `set_active`=1.
